// File: rtl/muxn_rr.sv
// N-input, WIDTH-bit mux with a registered output stage, valid/ready on every port,
// and fixed-select or round-robin arbitration. Define MUXN_STATS_EN to add xfer_count_o.
module muxn_rr #(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    parameter int SW    = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data_i,
    input  logic [N-1:0]       in_valid_i,
    output logic [N-1:0]       in_ready_o,
    input  logic               mode_i,
    input  logic [SW-1:0]      sel_i,
    output logic [WIDTH-1:0]   out_data_o,
    output logic               out_valid_o,
    input  logic               out_ready_i
`ifdef MUXN_STATS_EN
    ,
    output logic [15:0]        xfer_count_o
`endif
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SW-1:0]    rr_ptr_q, rr_ptr_d;

    logic             load_s;
    logic             gnt_vld_s;
    logic [SW-1:0]    gnt_idx_s;
    logic [WIDTH-1:0] gnt_data_s;
    logic [SW:0]      rr_sum_s;
    logic [SW-1:0]    rr_idx_s;

    assign load_s = !out_valid_q || out_ready_i;

    // Grant selection; the round-robin scan runs from the farthest offset down so the
    // nearest valid channel at or after rr_ptr_q is the last (winning) assignment.
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = '0;
        rr_sum_s  = '0;
        rr_idx_s  = '0;
        if (mode_i == 1'b0) begin
            for (int i = 0; i < N; i++) begin
                if ((sel_i == SW'(i)) && in_valid_i[i]) begin
                    gnt_vld_s = 1'b1;
                    gnt_idx_s = SW'(i);
                end else begin
                    gnt_vld_s = gnt_vld_s;
                end
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                rr_sum_s = {1'b0, rr_ptr_q} + (SW+1)'(k);
                if (rr_sum_s >= (SW+1)'(N)) begin
                    rr_sum_s = rr_sum_s - (SW+1)'(N);
                end else begin
                    rr_sum_s = rr_sum_s;
                end
                rr_idx_s = rr_sum_s[SW-1:0];
                if (in_valid_i[rr_idx_s]) begin
                    gnt_vld_s = 1'b1;
                    gnt_idx_s = rr_idx_s;
                end else begin
                    gnt_vld_s = gnt_vld_s;
                end
            end
        end
    end

    // Granted channel data and one-hot ready; ready is forced low while in reset.
    always_comb begin
        gnt_data_s = '0;
        in_ready_o = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_idx_s == SW'(i)) begin
                gnt_data_s    = in_data_i[i*WIDTH +: WIDTH];
                in_ready_o[i] = rst_n && load_s && gnt_vld_s;
            end else begin
                in_ready_o[i] = 1'b0;
            end
        end
    end

    // Output stage and round-robin pointer next state; everything holds while stalled.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_s) begin
            if (gnt_vld_s) begin
                out_data_d  = gnt_data_s;
                out_valid_d = 1'b1;
                if (mode_i) begin
                    rr_ptr_d = (gnt_idx_s == SW'(N - 1)) ? '0 : gnt_idx_s + SW'(1);
                end else begin
                    rr_ptr_d = rr_ptr_q;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;

`ifdef MUXN_STATS_EN
    logic [15:0] xfer_count_q, xfer_count_d;

    // Accepted-transfer counter, wraps naturally at 16 bits.
    always_comb begin
        if (out_valid_q && out_ready_i) begin
            xfer_count_d = xfer_count_q + 16'd1;
        end else begin
            xfer_count_d = xfer_count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count_q <= 16'd0;
        end else begin
            xfer_count_q <= xfer_count_d;
        end
    end

    assign xfer_count_o = xfer_count_q;
`endif

endmodule
